// File: rtl/scandoubler_pkg.sv
// Shared video definitions: 9-bit RGB pixel and 15 kHz -> 31 kHz doubling constants.
// Reused by the scandoubler, the OSD overlay and the board top level.
package scandoubler_pkg;

  localparam int unsigned SCANDBL_ADDR_W   = 9;
  localparam int unsigned VGA_HSYNC_W      = 54;
  localparam int unsigned SCANDBL_MIN_LINE = 256;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] r;
    logic [2:0] b;
  } rgb9_t;

endpackage

// File: rtl/scandoubler_linebuf.sv
// Two-bank line buffer: one write port, one synchronous read port.
// The bank select is the address MSB, so the whole array maps onto one block RAM.
module scandoubler_linebuf
  import scandoubler_pkg::*;
#(
  parameter int unsigned ADDR_W = SCANDBL_ADDR_W
) (
  input  logic              clk28,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_waddr,
  input  rgb9_t             i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W:0]   i_raddr,
  output rgb9_t             o_rdata
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  rgb9_t r_mem [DEPTH];
  rgb9_t r_rdata;

  // No reset on the array or the read register, which keeps the block RAM inferable.
  always_ff @(posedge clk28) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/scandoubler.sv
// Scandoubler: captures each 15 kHz input line at the 7 MHz strobe into one bank
// and replays the other bank twice at the 14 MHz strobe as a 31 kHz VGA stream.
module scandoubler
  import scandoubler_pkg::*;
#(
  parameter int unsigned ADDR_W   = SCANDBL_ADDR_W,
  parameter int unsigned HSYNC_W  = VGA_HSYNC_W,
  parameter int unsigned MIN_LINE = SCANDBL_MIN_LINE
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ck7,
  input  logic       ck14,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [2:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       second_half
);

  localparam logic [ADDR_W-1:0] X_MAX = '1;
  localparam logic [ADDR_W-1:0] X_MIN = ADDR_W'(MIN_LINE);
  localparam logic [ADDR_W-1:0] X_HS  = ADDR_W'(HSYNC_W);

  logic              r_hsync_d;
  logic [ADDR_W-1:0] r_wr_x;
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_line_len;
  logic              r_vsync_lat;
  logic [ADDR_W-1:0] r_rd_x;
  logic              r_second;
  logic              r_p1_valid;
  logic [ADDR_W-1:0] r_p1_x;
  logic              r_p1_vsync;
  rgb9_t             r_vga_rgb;
  logic              r_vga_hs;
  logic              r_vga_vs;

  logic              w_line_ev;
  logic              w_line_ok;
  logic              w_we;
  logic              w_len_valid;
  logic              w_rd_last;
  rgb9_t             w_wdata;
  rgb9_t             w_rdata;

  assign w_line_ev   = r_hsync_d & ~hsync_in;
  assign w_line_ok   = w_line_ev & (r_wr_x >= X_MIN);
  // Writing stops at the saturation address so a runaway line never wraps onto address 0.
  assign w_we        = ck7 & ~w_line_ev & (r_wr_x != X_MAX);
  assign w_len_valid = (r_line_len != '0);
  assign w_rd_last   = (r_rd_x == (r_line_len - ADDR_W'(1)));
  assign w_wdata     = rgb9_t'({g_in, r_in, b_in});

  // Capture side: line measurement, bank swap and write pointer.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_d   <= 1'b1;
      r_wr_x      <= '0;
      r_wr_bank   <= 1'b0;
      r_line_len  <= '0;
      r_vsync_lat <= 1'b1;
    end else begin
      r_hsync_d <= hsync_in;
      if (w_line_ev) begin
        r_wr_x <= '0;
        if (w_line_ok) begin
          r_line_len  <= r_wr_x;
          r_wr_bank   <= ~r_wr_bank;
          r_vsync_lat <= vsync_in;
        end
      end else if (w_we) begin
        r_wr_x <= r_wr_x + ADDR_W'(1);
      end
    end
  end

  // Replay side: a valid line event restarts the read pointer ahead of the wrap.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_x   <= '0;
      r_second <= 1'b0;
    end else if (w_line_ok) begin
      r_rd_x   <= '0;
      r_second <= 1'b0;
    end else if (ck14 && w_len_valid) begin
      if (w_rd_last) begin
        r_rd_x   <= '0;
        r_second <= 1'b1;
      end else begin
        r_rd_x <= r_rd_x + ADDR_W'(1);
      end
    end
  end

  scandoubler_linebuf #(
    .ADDR_W (ADDR_W)
  ) u_linebuf (
    .clk28   (clk28),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, r_wr_x}),
    .i_wdata (w_wdata),
    .i_re    (ck14),
    .i_raddr ({~r_wr_bank, r_rd_x}),
    .o_rdata (w_rdata)
  );

  // Sync and blanking follow the read address through the same two ck14 stages as the RAM data.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_valid <= 1'b0;
      r_p1_x     <= '0;
      r_p1_vsync <= 1'b1;
      r_vga_rgb  <= '0;
      r_vga_hs   <= 1'b1;
      r_vga_vs   <= 1'b1;
    end else if (ck14) begin
      r_p1_valid <= w_len_valid;
      r_p1_x     <= r_rd_x;
      r_p1_vsync <= r_vsync_lat;
      r_vga_rgb  <= r_p1_valid ? w_rdata : '0;
      r_vga_hs   <= ~(r_p1_valid && (r_p1_x < X_HS));
      r_vga_vs   <= r_p1_valid ? r_p1_vsync : 1'b1;
    end
  end

  assign vga_r       = r_vga_rgb.r;
  assign vga_g       = r_vga_rgb.g;
  assign vga_b       = r_vga_rgb.b;
  assign vga_hsync   = r_vga_hs;
  assign vga_vsync   = r_vga_vs;
  assign second_half = r_second;

endmodule

// File: tb/tb_scandoubler.sv
// Randomised bench for scandoubler: a queue-based line model predicts every output on every clk28.
module tb_scandoubler;

  localparam int MINL = 256;
  localparam int HSW  = 54;
  localparam int XSAT = 511;

  logic       clk28 = 1'b0;
  logic       rst_n;
  logic       ck7;
  logic       ck14;
  logic [2:0] r_in;
  logic [2:0] g_in;
  logic [2:0] b_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [2:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       second_half;

  scandoubler dut (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .ck7         (ck7),
    .ck14        (ck14),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .second_half (second_half)
  );

  always #5 clk28 = ~clk28;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a line is the list of pixels written since the last event;
  // the replayed pixel is that list indexed by (strobes since accepted event) mod length.
  typedef struct {
    bit valid;
    int pix;
    int x;
    bit vs;
  } rd_t;

  int  cap[$];
  int  line[$];
  int  len = 0;
  int  n = 0;
  bit  vlat = 1'b1;
  bit  prev_hs = 1'b1;
  bit  sec = 1'b0;
  rd_t s1;
  rd_t s2;

  bit  was14 = 1'b0;
  bit  prev_vhs = 1'b1;
  int  strobes = 0;
  int  period = 0;
  int  vs_lines = 0;
  int  ph;

  function automatic void model_reset();
    cap.delete();
    line.delete();
    len = 0;
    n = 0;
    vlat = 1'b1;
    prev_hs = 1'b1;
    sec = 1'b0;
    s1.valid = 1'b0;
    s1.pix = 0;
    s1.x = 0;
    s1.vs = 1'b1;
    s2 = s1;
  endfunction

  function automatic void model_step();
    bit ev;
    int px;
    ev = prev_hs && !hsync_in;
    prev_hs = hsync_in;
    px = 32'({g_in, r_in, b_in});
    if (ck14) begin
      s2 = s1;
      if (len != 0) begin
        s1.valid = 1'b1;
        s1.x = n % len;
        s1.pix = line[s1.x];
        s1.vs = vlat;
      end else begin
        s1.valid = 1'b0;
        s1.pix = 0;
        s1.x = 0;
        s1.vs = 1'b1;
      end
    end
    if (ev && cap.size() >= MINL) begin
      line = cap;
      len = cap.size();
      n = 0;
      vlat = vsync_in;
    end else if (ck14 && len != 0) begin
      n++;
    end
    if (ev) cap.delete();
    else if (ck7 && cap.size() < XSAT) cap.push_back(px);
    sec = (len != 0) && (n >= len);
  endfunction

  // Compare the outcome of the last posedge, then predict the next one from the held inputs.
  always @(negedge clk28) begin
    if (!rst_n) model_reset();
    check("rgb", 32'({vga_g, vga_r, vga_b}), s2.valid ? s2.pix : 0);
    check("hsync", 32'(vga_hsync), (s2.valid && s2.x < HSW) ? 0 : 1);
    check("vsync", 32'(vga_vsync), s2.valid ? 32'(s2.vs) : 1);
    check("second_half", 32'(second_half), 32'(sec));
    if (was14) strobes++;
    if (prev_vhs && !vga_hsync) begin
      period = strobes;
      strobes = 0;
      if (!vga_vsync) vs_lines++;
    end
    prev_vhs = vga_hsync;
    was14 = ck14;
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk28);
    #1;
    ph = (ph + 1) % 4;
    ck7 = (ph == 0);
    ck14 = (ph % 2 == 0);
  endtask

  // One 7 MHz pixel slot; hsync may change dly clk28 cycles into the slot.
  task automatic pix7(input int px, input bit hs, input bit vs, input int dly);
    logic [8:0] pv;
    pv = 9'(px);
    g_in = pv[8:6];
    r_in = pv[5:3];
    b_in = pv[2:0];
    vsync_in = vs;
    for (int t = 0; t < 4; t++) begin
      if (t == dly) hsync_in = hs;
      tick();
    end
  endtask

  task automatic gen_line(input int len_px, input int hs_at, input int gl_at,
                          input bit vs, input bit rnd, input int dly);
    for (int x = 0; x < len_px; x++) begin
      int pxv;
      bit hs;
      pxv = rnd ? int'($urandom_range(0, 511)) : x % 512;
      hs = !((x >= hs_at && x < hs_at + 33) || (x >= gl_at && x < gl_at + 4));
      pix7(pxv, hs, vs, dly);
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    ck7 = 1'b0;
    ck14 = 1'b0;
    ph = 1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    r_in = '0;
    g_in = '0;
    b_in = '0;
    repeat (8) tick();
    rst_n = 1'b1;

    repeat (4) gen_line(448, 322, -100, 1'b1, 1'b0, 0);
    check("period_448", period, 448);

    repeat (3) gen_line(456, 322, -100, 1'b1, 1'b0, 0);
    check("period_456", period, 456);

    repeat (2) gen_line(448, 322, -100, 1'b1, 1'b0, 0);
    gen_line(448, 322, 422, 1'b1, 1'b0, 0);
    check("period_glitch", period, 448);
    gen_line(448, 322, -100, 1'b1, 1'b0, 0);

    gen_line(600, 10000, -100, 1'b1, 1'b0, 0);
    repeat (3) gen_line(448, 322, -100, 1'b1, 1'b0, 0);

    base = vs_lines;
    repeat (8) gen_line(448, 322, -100, 1'b0, 1'b0, 0);
    repeat (2) gen_line(448, 322, -100, 1'b1, 1'b0, 0);
    check("vsync_lines", vs_lines - base, 16);

    repeat (6) begin
      int l_px;
      int h_at;
      l_px = int'($urandom_range(300, 500));
      h_at = int'($urandom_range(150, 32'(l_px - 40)));
      gen_line(l_px, h_at, -100, 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 3)));
    end
    gen_line(150, 60, -100, 1'b1, 1'b1, 0);
    repeat (2) gen_line(448, 322, -100, 1'b1, 1'b1, 1);

    for (int x = 0; x < 200; x++) pix7(x, 1'b1, 1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rgb", 32'({vga_g, vga_r, vga_b}), 0);
    check("rst_hsync", 32'(vga_hsync), 1);
    check("rst_vsync", 32'(vga_vsync), 1);
    check("rst_second", 32'(second_half), 0);
    repeat (6) tick();
    rst_n = 1'b1;
    while (ph != 1) tick();
    repeat (3) gen_line(448, 322, -100, 1'b1, 1'b0, 0);
    check("period_after_reset", period, 448);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scandoubler.md
Name: scandoubler

Overview:
- Receiving end of the 15 kHz video stream the screen generator produces: 9-bit RGB, active-low hsync and vsync, on the 7 MHz pixel strobe.
- Captures each incoming line into one bank of a two-bank line buffer.
- Replays the other bank twice at 14 MHz, producing a 31 kHz VGA-compatible stream.
- Sits between the screen generator outputs and the board VGA pins; selected by the top level when VGA mode is enabled.

Parameters:
- ADDR_W, 9, line-buffer address width; capacity 2^ADDR_W pixels per bank.
- HSYNC_W, 54, output hsync pulse width in 14 MHz pixels.
- MIN_LINE, 256, shortest accepted input line in 7 MHz pixels; shorter lines are discarded as glitches.

Ports:
- clk28  input  1  28 MHz system clock.
- rst_n  input  1  asynchronous, active-low reset.
- ck7  input  1  one-clk28 enable, 7 MHz input pixel strobe.
- ck14  input  1  one-clk28 enable, 14 MHz output pixel strobe.
- r_in, g_in, b_in  input  3 each  incoming pixel colour.
- hsync_in  input  1  incoming horizontal sync, active low.
- vsync_in  input  1  incoming vertical sync, active low.
- vga_r, vga_g, vga_b  output  3 each  doubled pixel colour.
- vga_hsync  output  1  output horizontal sync, active low.
- vga_vsync  output  1  output vertical sync, active low.
- second_half  output  1  high during the repeated (second) output copy of a line.

Behaviour:
- Reset (async):
  - all vga_* colour outputs 0; vga_hsync = 1; vga_vsync = 1; second_half = 0.
  - wr_x = 0, rd_x = 0, line_len = 0, wr_bank = 0.
- Line event: falling edge of hsync_in, detected from a one-clk28-delayed register.
  - If wr_x ≥ MIN_LINE:
    - line_len ← wr_x;
    - wr_bank toggles;
    - rd_x ← 0; second_half ← 0;
    - vsync_lat ← vsync_in.
  - If wr_x < MIN_LINE: the event is ignored except wr_x ← 0.
  - In both cases wr_x ← 0.
- Capture:
  - On each ck7 not coinciding with a line event, write {g_in, r_in, b_in} to bank wr_bank at address wr_x.
  - wr_x then increments, saturating at 2^ADDR_W − 1.
  - Once saturated, no further writes occur: no wrap and no overwrite of address 0.
- Replay, on each ck14:
  - read bank ~wr_bank at address rd_x.
  - If rd_x == line_len − 1: rd_x ← 0; second_half ← 1, or holds 1 if already set.
  - Otherwise rd_x increments.
  - Each line is therefore replayed exactly twice per input line.
  - A line event has priority over the wrap.
  - If a third pass would begin before the next line event (input line longer than measured), replay repeats; second_half stays 1.
- line_len == 0 (before the first valid line after reset):
  - rd_x is held at 0;
  - colour outputs are 0;
  - vga_hsync and vga_vsync stay 1.
- Pipeline:
  - RAM read is synchronous.
  - Colour, hsync and vsync are all registered so that pixel rd_x = n appears on vga_* exactly 2 ck14 strobes after rd_x = n was presented.
  - Sync and colour stay mutually aligned.
- vga_hsync = 0 while the pipelined rd_x < HSYNC_W; otherwise 1.
- vga_vsync = vsync_lat, sampled at each line event and held for both output copies.
- Width: line_len and rd_x are ADDR_W bits, and the rd_x compare is unsigned.
- The ck7 and ck14 strobes may coincide on one clk28 edge; capture and replay proceed independently.
- Read and write never target the same bank in the same cycle, so no collision logic is needed.

Decomposition:
- Shared package holds:
  - RGB9 pixel typedef {g, r, b};
  - VGA_HSYNC_W and SCANDBL_MIN_LINE constants;
  - these are reused by the OSD overlay and the top level.
- Sub-module scandoubler_linebuf:
  - simple dual-port RAM, 2 × 2^ADDR_W × 9;
  - one write port, one synchronous read port;
  - bank bit is the address MSB;
  - inferable as block RAM.

Test Plan:
- Reset released, then 448-pixel lines with pixel value = x mod 512 and hsync low at x 322..354 → after the second line:
  - line_len = 448;
  - vga_* emits ramp 0..447 twice per input line, 448 ck14 each;
  - second_half toggles 0→1 at the midpoint.
- Line length changes 448 → 456 (S128) mid-frame → next replay uses line_len = 456; no pixel lost or duplicated at the switch.
- hsync_in glitch: low pulse after 100 pixels → ignored; line_len unchanged; wr_x restarts at 0.
- hsync_in stuck high for 600 ck7 → wr_x saturates at 511; address 0 is not overwritten; replay continues looping the last valid line.
- vsync_in low for 8 input lines → vga_vsync low for exactly 16 output lines, aligned to output line starts.
- rst_n asserted mid-line → outputs go to reset values immediately; hsync and vsync stay inactive until the first valid line event.
